// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational reads, two prioritised writes,
// optional bypass and zero register, plus a dirty bitmap of written registers.
module regfile_mp #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 3,
    parameter int NUM_RD     = 2,
    parameter int RESET_MODE = 1,
    parameter int ZERO_REG   = 0,
    parameter int BYPASS     = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    input  logic                       we_a,
    input  logic [ADDR_W-1:0]          wa_addr,
    input  logic [DATA_W-1:0]          wa_data,
    input  logic                       we_b,
    input  logic [ADDR_W-1:0]          wb_addr,
    input  logic [DATA_W-1:0]          wb_data,
    input  logic                       clear_dirty,
    output logic [(2**ADDR_W)-1:0]     dirty
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  dirty_q;
    logic [DEPTH-1:0]  dirty_d;

    logic              wa_ok;
    logic              wb_ok;
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rv;

    function automatic logic [DATA_W-1:0] rst_val(input int idx);
        if (RESET_MODE == 1 && !(ZERO_REG == 1 && idx == 0)) begin
            return DATA_W'(idx);
        end
        return '0;
    endfunction

    // A write to the zero register is not a write at all: no data, no dirty bit.
    always_comb begin
        wa_ok = we_a;
        wb_ok = we_b;
        if (ZERO_REG == 1) begin
            wa_ok = we_a && (wa_addr != '0);
            wb_ok = we_b && (wb_addr != '0);
        end
    end

    always_comb begin
        regs_d  = regs_q;
        dirty_d = dirty_q;
        if (clear_dirty) begin
            dirty_d = '0;
        end
        if (wa_ok) begin
            regs_d[wa_addr]  = wa_data;
            dirty_d[wa_addr] = 1'b1;
        end
        // Port B applied last so it wins an address collision.
        if (wb_ok) begin
            regs_d[wb_addr]  = wb_data;
            dirty_d[wb_addr] = 1'b1;
        end
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_d[i] = rst_val(i);
            end
            dirty_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        regs_q  <= regs_d;
        dirty_q <= dirty_d;
    end

    always_comb begin
        rd_data = '0;
        ra      = '0;
        rv      = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            ra = rd_addr[k*ADDR_W +: ADDR_W];
            rv = regs_q[ra];
            if (BYPASS == 1 && !reset) begin
                if (we_b && wb_addr == ra) begin
                    rv = wb_data;
                end else if (we_a && wa_addr == ra) begin
                    rv = wa_data;
                end
            end
            if (ZERO_REG == 1 && ra == '0) begin
                rv = '0;
            end
            rd_data[k*DATA_W +: DATA_W] = rv;
        end
    end

    assign dirty = dirty_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: four configurations driven in parallel, checked
// every cycle against an array model plus literal expectations.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] rd_addr_w;
    logic        we_a, we_b, clear_dirty;
    logic [3:0]  wa_addr_w, wb_addr_w;
    logic [15:0] wa_data_w, wb_data_w;

    logic [15:0] rd0, rd1, rd2;
    logic [63:0] rd3;
    logic [7:0]  dirty0, dirty1, dirty2;
    logic [15:0] dirty3;

    int errors = 0;
    int checks = 0;
    bit started = 1'b0;

    int cdw [4] = '{8, 8, 8, 16};
    int caw [4] = '{3, 3, 3, 4};
    int cnr [4] = '{2, 2, 2, 4};
    int crm [4] = '{1, 1, 1, 0};
    int czr [4] = '{0, 0, 1, 0};
    int cbp [4] = '{0, 1, 1, 1};

    logic [15:0] mr [4][16];
    logic [15:0] md [4];

    always #5 clk = ~clk;

    wire [5:0] rda_s = {rd_addr_w[6:4], rd_addr_w[2:0]};

    regfile_mp #(.DATA_W(8), .ADDR_W(3), .NUM_RD(2), .RESET_MODE(1),
                 .ZERO_REG(0), .BYPASS(0)) u0 (
        .clk(clk), .reset(reset), .rd_addr(rda_s), .rd_data(rd0),
        .we_a(we_a), .wa_addr(wa_addr_w[2:0]), .wa_data(wa_data_w[7:0]),
        .we_b(we_b), .wb_addr(wb_addr_w[2:0]), .wb_data(wb_data_w[7:0]),
        .clear_dirty(clear_dirty), .dirty(dirty0));

    regfile_mp #(.DATA_W(8), .ADDR_W(3), .NUM_RD(2), .RESET_MODE(1),
                 .ZERO_REG(0), .BYPASS(1)) u1 (
        .clk(clk), .reset(reset), .rd_addr(rda_s), .rd_data(rd1),
        .we_a(we_a), .wa_addr(wa_addr_w[2:0]), .wa_data(wa_data_w[7:0]),
        .we_b(we_b), .wb_addr(wb_addr_w[2:0]), .wb_data(wb_data_w[7:0]),
        .clear_dirty(clear_dirty), .dirty(dirty1));

    regfile_mp #(.DATA_W(8), .ADDR_W(3), .NUM_RD(2), .RESET_MODE(1),
                 .ZERO_REG(1), .BYPASS(1)) u2 (
        .clk(clk), .reset(reset), .rd_addr(rda_s), .rd_data(rd2),
        .we_a(we_a), .wa_addr(wa_addr_w[2:0]), .wa_data(wa_data_w[7:0]),
        .we_b(we_b), .wb_addr(wb_addr_w[2:0]), .wb_data(wb_data_w[7:0]),
        .clear_dirty(clear_dirty), .dirty(dirty2));

    regfile_mp #(.DATA_W(16), .ADDR_W(4), .NUM_RD(4), .RESET_MODE(0),
                 .ZERO_REG(0), .BYPASS(1)) u3 (
        .clk(clk), .reset(reset), .rd_addr(rd_addr_w), .rd_data(rd3),
        .we_a(we_a), .wa_addr(wa_addr_w), .wa_data(wa_data_w),
        .we_b(we_b), .wb_addr(wb_addr_w), .wb_data(wb_data_w),
        .clear_dirty(clear_dirty), .dirty(dirty3));

    function automatic int amask(int j);
        return (1 << caw[j]) - 1;
    endfunction

    function automatic logic [15:0] dmask(int j);
        return (cdw[j] == 16) ? 16'hFFFF : 16'h00FF;
    endfunction

    function automatic logic [15:0] act_rd(int j, int k);
        case (j)
            0: return {8'h00, rd0[k*8 +: 8]};
            1: return {8'h00, rd1[k*8 +: 8]};
            2: return {8'h00, rd2[k*8 +: 8]};
            default: return rd3[k*16 +: 16];
        endcase
    endfunction

    function automatic logic [15:0] act_dirty(int j);
        case (j)
            0: return {8'h00, dirty0};
            1: return {8'h00, dirty1};
            2: return {8'h00, dirty2};
            default: return dirty3;
        endcase
    endfunction

    // Expected read value from the model array and the current inputs.
    function automatic logic [15:0] exp_rd(int j, int k);
        int a, wa, wb;
        logic [15:0] v;
        a  = int'((rd_addr_w >> (4*k)) & 16'hF) & amask(j);
        wa = int'(wa_addr_w) & amask(j);
        wb = int'(wb_addr_w) & amask(j);
        v  = mr[j][a];
        if (cbp[j] == 1 && !reset) begin
            if (we_b && wb == a) v = wb_data_w & dmask(j);
            else if (we_a && wa == a) v = wa_data_w & dmask(j);
        end
        if (czr[j] == 1 && a == 0) v = 16'h0;
        return v;
    endfunction

    always @(posedge clk) begin
        for (int j = 0; j < 4; j++) begin
            int wa, wb;
            wa = int'(wa_addr_w) & amask(j);
            wb = int'(wb_addr_w) & amask(j);
            if (reset) begin
                for (int i = 0; i < 16; i++) begin
                    mr[j][i] = (crm[j] == 1) ? (16'(i) & dmask(j)) : 16'h0;
                end
                if (czr[j] == 1) mr[j][0] = 16'h0;
                md[j] = 16'h0;
            end else begin
                if (clear_dirty) md[j] = 16'h0;
                if (we_a && !(czr[j] == 1 && wa == 0)) begin
                    mr[j][wa] = wa_data_w & dmask(j);
                    md[j][wa] = 1'b1;
                end
                if (we_b && !(czr[j] == 1 && wb == 0)) begin
                    mr[j][wb] = wb_data_w & dmask(j);
                    md[j][wb] = 1'b1;
                end
            end
        end
        if (reset) started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            for (int j = 0; j < 4; j++) begin
                for (int k = 0; k < cnr[j]; k++) begin
                    checks++;
                    if (act_rd(j, k) !== exp_rd(j, k)) begin
                        errors++;
                        $display("FAIL rd u%0d port%0d t=%0t: got %h expected %h",
                                 j, k, $time, act_rd(j, k), exp_rd(j, k));
                    end
                end
                checks++;
                if (act_dirty(j) !== md[j]) begin
                    errors++;
                    $display("FAIL dirty u%0d t=%0t: got %h expected %h",
                             j, $time, act_dirty(j), md[j]);
                end
            end
        end
    end

    // Literal check of both DUT and model read value.
    task automatic lit(input string nm, input int j, input int k,
                       input logic [15:0] exp);
        checks++;
        if (act_rd(j, k) !== exp) begin
            errors++;
            $display("FAIL %s u%0d port%0d: got %h expected %h",
                     nm, j, k, act_rd(j, k), exp);
        end
        checks++;
        if (exp_rd(j, k) !== exp) begin
            errors++;
            $display("FAIL %s model u%0d port%0d: got %h expected %h",
                     nm, j, k, exp_rd(j, k), exp);
        end
    endtask

    task automatic lit_dirty(input string nm, input int j,
                             input logic [15:0] exp);
        checks++;
        if (act_dirty(j) !== exp) begin
            errors++;
            $display("FAIL %s u%0d: got %h expected %h",
                     nm, j, act_dirty(j), exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic setrd(input int a0, input int a1, input int a2, input int a3);
        rd_addr_w = {4'(a3), 4'(a2), 4'(a1), 4'(a0)};
    endtask

    task automatic idle;
        we_a = 1'b0; we_b = 1'b0; clear_dirty = 1'b0;
        wa_addr_w = '0; wb_addr_w = '0;
        wa_data_w = '0; wb_data_w = '0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        setrd(0, 0, 0, 0);
        tick();
        tick();
        reset = 1'b0;

        // Reset contents, swept over all addresses.
        for (int i = 0; i < 8; i++) begin
            setrd(i, 7 - i, i + 8, 15 - i);
            #2;
            lit("rst_u0", 0, 0, 16'(i));
            lit("rst_u1", 1, 1, 16'(7 - i));
            lit("rst_u3", 3, 2, 16'h0);
            tick();
        end
        lit_dirty("rst_dirty", 0, 16'h0);

        // Single write, bypass vs no bypass.
        we_a = 1'b1; wa_addr_w = 4'd3; wa_data_w = 16'h00A5;
        setrd(3, 0, 0, 0);
        #2;
        lit("wr_nobyp", 0, 0, 16'h0003);
        lit("wr_byp", 1, 0, 16'h00A5);
        tick();
        idle();
        #2;
        lit("wr_next", 0, 0, 16'h00A5);
        lit_dirty("wr_dirty", 0, 16'h0008);
        tick();

        // Same-address collision: B wins.
        we_a = 1'b1; wa_addr_w = 4'd5; wa_data_w = 16'h0011;
        we_b = 1'b1; wb_addr_w = 4'd5; wb_data_w = 16'h0022;
        setrd(5, 5, 5, 5);
        #2;
        lit("coll_byp0", 1, 0, 16'h0022);
        lit("coll_byp1", 1, 1, 16'h0022);
        lit("coll_nobyp", 0, 0, 16'h0005);
        tick();
        idle();
        #2;
        lit("coll_next", 0, 0, 16'h0022);
        lit_dirty("coll_dirty", 0, 16'h0028);
        tick();

        // Zero register.
        we_a = 1'b1; wa_addr_w = 4'd0; wa_data_w = 16'h00FF;
        setrd(0, 0, 0, 0);
        #2;
        lit("zr_same0", 2, 0, 16'h0000);
        lit("zr_same1", 2, 1, 16'h0000);
        lit("zr_other", 1, 0, 16'h00FF);
        tick();
        idle();
        #2;
        lit("zr_next", 2, 0, 16'h0000);
        lit("zr_plain", 0, 0, 16'h00FF);
        lit_dirty("zr_dirty", 2, 16'h0028);
        tick();

        // Clear together with a write: set beats clear.
        we_b = 1'b1; wb_addr_w = 4'd6; wb_data_w = 16'h0066;
        tick();
        idle();
        clear_dirty = 1'b1;
        we_a = 1'b1; wa_addr_w = 4'd2; wa_data_w = 16'h007E;
        tick();
        idle();
        setrd(2, 6, 0, 0);
        #2;
        lit_dirty("clr_dirty0", 0, 16'h0004);
        lit_dirty("clr_dirty3", 3, 16'h0004);
        lit("clr_data", 0, 0, 16'h007E);
        lit("clr_keep", 0, 1, 16'h0066);
        tick();

        // Wide instance: four independent read ports.
        we_a = 1'b1; wa_addr_w = 4'd9;  wa_data_w = 16'h1234;
        we_b = 1'b1; wb_addr_w = 4'd15; wb_data_w = 16'hBEEF;
        tick();
        idle();
        setrd(9, 15, 2, 0);
        #2;
        lit("w4_p0", 3, 0, 16'h1234);
        lit("w4_p1", 3, 1, 16'hBEEF);
        lit("w4_p2", 3, 2, 16'h007E);
        lit("w4_p3", 3, 3, 16'h00FF);
        tick();

        // Reset overrides a concurrent write and suppresses bypass.
        reset = 1'b1;
        we_a = 1'b1; wa_addr_w = 4'd4; wa_data_w = 16'h0099;
        setrd(4, 9, 15, 2);
        #2;
        lit("rst_nobyp", 1, 0, 16'h0004);
        tick();
        reset = 1'b0;
        idle();
        #2;
        lit("rstw_u0", 0, 0, 16'h0004);
        lit("rstw_u0p1", 0, 1, 16'h0001);
        lit("rstw_u3p0", 3, 0, 16'h0000);
        lit("rstw_u3p1", 3, 1, 16'h0000);
        lit("rstw_u3p2", 3, 2, 16'h0000);
        lit("rstw_u3p3", 3, 3, 16'h0000);
        lit_dirty("rstw_dirty0", 0, 16'h0000);
        lit_dirty("rstw_dirty3", 3, 16'h0000);
        tick();

        // Pattern sweep; the per-cycle compare checks it.
        for (int i = 0; i < 16; i++) begin
            we_a = 1'b1; wa_addr_w = 4'(i); wa_data_w = 16'(i * 16'h0111);
            we_b = (i % 3 == 0);
            wb_addr_w = 4'(15 - i); wb_data_w = 16'(16'hF00F ^ i);
            clear_dirty = (i == 10);
            setrd(i, (i + 1) % 16, 15 - i, 0);
            tick();
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            setrd(i * 4, i * 4 + 1, i * 4 + 2, i * 4 + 3);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the 8-bit processor datapath and its wider variants. It stores 2**ADDR_W registers of DATA_W bits and provides NUM_RD combinational read ports and two prioritised write ports. Optional features are write-to-read bypass, a hardwired zero register, and selectable reset contents. A per-register dirty bitmap lets the controller and debug logic track which registers were written since the last clear.

## Interface
Parameters:
- DATA_W, 8, register width in bits (≥ 2)
- ADDR_W, 3, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- RESET_MODE, 1, 0 = reset all registers to zero; 1 = reset R[i] = i truncated to DATA_W
- ZERO_REG, 0, 1 = R[0] always reads 0 and ignores writes
- BYPASS, 0, 1 = same-cycle write data is forwarded to matching read ports

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  reset; synchronous, active-high
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data; port k uses bits [k*DATA_W +: DATA_W]
- we_a  in  1  write enable, port A
- wa_addr  in  ADDR_W  write address, port A
- wa_data  in  DATA_W  write data, port A
- we_b  in  1  write enable, port B (higher priority)
- wb_addr  in  ADDR_W  write address, port B
- wb_data  in  DATA_W  write data, port B
- clear_dirty  in  1  clears the dirty bitmap
- dirty  out  2**ADDR_W  bit i = 1 if R[i] was written since the last reset or clear

## Operation
- Storage is an array R[0 .. 2**ADDR_W-1] of DATA_W-bit flops.
- Reset (sampled at the edge) loads R[i] per RESET_MODE and clears dirty to 0. Writes and clear_dirty are ignored during a reset cycle.
- Writes:
  - At the edge, if we_a is set, R[wa_addr] ← wa_data. If we_b is set, R[wb_addr] ← wb_data.
  - If both ports target the same address, port B wins.
  - Different addresses are both written.
- ZERO_REG=1:
  - Writes to address 0 are dropped and dirty[0] stays 0.
  - Every read of address 0 returns 0, including any bypass result.
  - With RESET_MODE=1, R[0] resets to 0 regardless.
- Reads are combinational from the array:
  - rd_data[k] = R[rd_addr[k]].
  - With BYPASS=1, if we_b is set and wb_addr equals rd_addr[k], the port returns wb_data.
  - Otherwise, if we_a is set and wa_addr equals rd_addr[k], the port returns wa_data.
  - Otherwise the port returns R[rd_addr[k]].
  - Bypass is suppressed while reset is high.
- Dirty bitmap:
  - Each accepted write sets dirty[addr] at the edge.
  - clear_dirty clears all bits at the edge.
  - When clear_dirty and a write occur in the same cycle, the written register's bit ends at 1 (set beats clear); all other bits clear.
- Addresses are full-range (no out-of-range case). Data is stored unmodified; there is no arithmetic.

## Timing
- Write latency: data is visible on the read ports in the cycle after the write edge. With BYPASS=1 it is also visible combinationally in the same cycle as we_*.
- Read latency: 0 cycles (combinational path from rd_addr and the array to rd_data).
- Reset values:
  - R per RESET_MODE.
  - dirty = 0.
  - rd_data reflects the reset contents from the cycle after the reset edge.
- Reset asserted mid-operation overrides any concurrent write at that edge. The first write accepted is the one presented in the cycle reset is low.
- Before the first reset, contents and dirty are undefined (X in simulation). The bench must reset first.
- No handshakes: every write with we_* high at an edge is accepted.

## Test plan
- Reset with defaults (DATA_W=8, ADDR_W=3, RESET_MODE=1) → reading addresses 0..7 returns 0x00..0x07; dirty = 0x00.
- Set we_a=1, wa_addr=3, wa_data=0xA5, read rd_addr[0]=3 → BYPASS=0: reads 0x03 in the write cycle, 0xA5 the next cycle; BYPASS=1: reads 0xA5 in the same cycle. dirty = 0x08 after the edge.
- Same-cycle collision: we_a=1 (addr 5, 0x11) and we_b=1 (addr 5, 0x22) → R[5] = 0x22. With BYPASS=1, rd_data on addr 5 is 0x22 in that cycle. dirty[5] = 1.
- ZERO_REG=1: write 0xFF to addr 0 → all read ports on addr 0 return 0x00 in both the write cycle and the next cycle; dirty[0] = 0.
- clear_dirty=1 together with a write of 0x7E to addr 2 (after earlier writes to addrs 3 and 6) → dirty = 0x04 after the edge; R[2] = 0x7E.
- Assert reset together with a write of 0x99 to addr 4 → R[4] = 0x04 (RESET_MODE=1) or 0x00 (RESET_MODE=0); dirty = 0. Repeat with NUM_RD=4, DATA_W=16, ADDR_W=4 and check all four read ports independently.
